// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port memory.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT watchdog.
module mem_arbiter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  r0_valid,
  input  logic                  r0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wdata,
  output logic                  r0_ready,
  output logic [WIDTH-1:0]      r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_valid,
  input  logic                  r1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  output logic                  r1_ready,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_err,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  busy_q, busy_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
  logic                  r0_ready_q, r0_ready_d;
  logic                  r1_ready_q, r1_ready_d;
  logic                  r0_err_q, r0_err_d;
  logic                  r1_err_q, r1_err_d;
  logic [WIDTH-1:0]      r0_rdata_q, r0_rdata_d;
  logic [WIDTH-1:0]      r1_rdata_q, r1_rdata_d;

  logic                  grant;
  logic                  resp_go;
  logic                  resp_err;
  logic [WIDTH-1:0]      resp_data;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    m_valid_d  = 1'b0;
    m_wr_rd_d  = m_wr_rd_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    r0_ready_d = 1'b0;
    r1_ready_d = 1'b0;
    r0_err_d   = 1'b0;
    r1_err_d   = 1'b0;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    grant      = 1'b0;
    resp_go    = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          // With both pending the pointer decides; otherwise the lone requester wins.
          grant     = (r0_valid && r1_valid) ? ptr_q : r1_valid;
          gnt_id_d  = grant;
          m_wr_rd_d = grant ? r1_wr_rd : r0_wr_rd;
          m_addr_d  = grant ? r1_addr  : r0_addr;
          m_wdata_d = grant ? r1_wdata : r0_wdata;
          m_valid_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (m_ready) begin
          resp_go   = 1'b1;
          resp_data = m_wr_rd_q ? '0 : m_rdata;
        end else if (cnt_q == CNT_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (resp_go) begin
          state_d = RESP;
          if (gnt_id_q) begin
            r1_ready_d = 1'b1;
            r1_rdata_d = resp_data;
            r1_err_d   = resp_err;
          end else begin
            r0_ready_d = 1'b1;
            r0_rdata_d = resp_data;
            r0_err_d   = resp_err;
          end
        end
      end
      RESP: begin
        // Hand priority to whoever did not just get served.
        ptr_d   = ~gnt_id_q;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_id_q   <= 1'b0;
      busy_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_wr_rd_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      m_valid_q  <= m_valid_d;
      m_wr_rd_q  <= m_wr_rd_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      r0_ready_q <= r0_ready_d;
      r1_ready_q <= r1_ready_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_wr_rd  = m_wr_rd_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign r0_ready = r0_ready_q;
  assign r0_rdata = r0_rdata_q;
  assign r0_err   = r0_err_q;
  assign r1_ready = r1_ready_q;
  assign r1_rdata = r1_rdata_q;
  assign r1_err   = r1_err_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_id_q;

endmodule
